// File: rtl/insa_buf_ctrl_pkg.sv
// Shared types and constants for the INSA bounds buffer controller.
package insa_buf_ctrl_pkg;

    localparam int unsigned INSA_BUF_DEPTH = 1024;
    localparam int unsigned INSA_IDX_W     = 20;

    typedef struct packed {
        logic [31:0] first;
        logic [31:0] last;
        logic        valid;
    } insa_buf_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } insa_req_src_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } insa_buf_state_e;

endpackage

// File: rtl/insa_buf_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (ALU / LSU) with a 1-bit favour pointer.
module insa_rr_arb2
    import insa_buf_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_alu,
    input  logic req_lsu,
    output logic gnt_alu,
    output logic gnt_lsu
);

    insa_req_src_e favour;

    // Combinational grant: a lone requester wins, a tie goes to the favoured side.
    always_comb begin
        gnt_alu = en & req_alu & (~req_lsu | (favour == SRC_ALU));
        gnt_lsu = en & req_lsu & (~req_alu | (favour == SRC_LSU));
    end

    // Favour the side that was not granted most recently; hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour <= SRC_ALU;
        end else if (gnt_alu) begin
            favour <= SRC_LSU;
        end else if (gnt_lsu) begin
            favour <= SRC_ALU;
        end
    end

endmodule

// File: rtl/insa_buf_ctrl.sv
// Read-port arbiter and clear sequencer for the single-port INSA bounds buffer.
module insa_buf_ctrl
    import insa_buf_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = INSA_BUF_DEPTH,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alu_req_i,
    input  logic [INSA_IDX_W-1:0] alu_idx_i,
    output logic                  alu_gnt_o,
    output logic                  alu_rvalid_o,
    output logic [31:0]           alu_first_o,
    output logic [31:0]           alu_last_o,
    output logic                  alu_hit_o,
    input  logic                  lsu_req_i,
    input  logic [INSA_IDX_W-1:0] lsu_idx_i,
    output logic                  lsu_gnt_o,
    output logic                  lsu_rvalid_o,
    output logic [31:0]           lsu_first_o,
    output logic [31:0]           lsu_last_o,
    output logic                  lsu_hit_o,
    input  logic                  clr_req_i,
    output logic                  clr_busy_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [IDX_W-1:0]      mem_addr_o,
    input  logic [31:0]           mem_first_i,
    input  logic [31:0]           mem_last_i,
    input  logic                  mem_valid_i
);

    localparam logic [INSA_IDX_W:0] DEPTH_EXT = (INSA_IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_ADDR = IDX_W'(DEPTH - 1);

    insa_buf_state_e       state;
    logic [IDX_W-1:0]      clr_cnt;
    logic                  grant_en;
    logic                  gnt_alu;
    logic                  gnt_lsu;
    logic                  gnt_any;
    logic [INSA_IDX_W-1:0] gnt_idx;
    logic                  gnt_in_range;
    logic                  rsp_valid;
    insa_req_src_e         rsp_owner;
    logic                  rsp_in_range;
    insa_buf_entry_t       rsp_entry;

    // A clear request in IDLE pre-empts any read in the same cycle; reset also masks grants.
    always_comb begin
        grant_en = rst_ni & (state == ST_IDLE) & ~clr_req_i;
    end

    insa_rr_arb2 u_arb (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .en      (grant_en),
        .req_alu (alu_req_i),
        .req_lsu (lsu_req_i),
        .gnt_alu (gnt_alu),
        .gnt_lsu (gnt_lsu)
    );

    // Select the granted index and decide whether it addresses a real entry.
    always_comb begin
        gnt_any      = gnt_alu | gnt_lsu;
        gnt_idx      = gnt_lsu ? lsu_idx_i : alu_idx_i;
        gnt_in_range = ({1'b0, gnt_idx} < DEPTH_EXT);
        alu_gnt_o    = gnt_alu;
        lsu_gnt_o    = gnt_lsu;
    end

    // RAM port: clear writes own the port in CLEAR, otherwise an in-range granted read.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        if (state == ST_CLEAR) begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = clr_cnt;
        end else if (gnt_any && gnt_in_range) begin
            mem_req_o  = 1'b1;
            mem_addr_o = gnt_idx[IDX_W-1:0];
        end
    end

    // Clear sequencer: walks every address once, ignoring further clear pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req_i) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + IDX_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        clr_busy_o = (state == ST_CLEAR);
    end

    // Remember who owns the in-flight read and whether it touched the RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid    <= 1'b0;
            rsp_owner    <= SRC_ALU;
            rsp_in_range <= 1'b0;
        end else begin
            rsp_valid    <= gnt_any;
            rsp_owner    <= gnt_lsu ? SRC_LSU : SRC_ALU;
            rsp_in_range <= gnt_in_range;
        end
    end

    // Route the RAM data to the owner; everything reads as zero without a live in-range response.
    always_comb begin
        rsp_entry = '0;
        if (rsp_valid && rsp_in_range) begin
            rsp_entry = '{first: mem_first_i, last: mem_last_i, valid: mem_valid_i};
        end
        alu_rvalid_o = rsp_valid & (rsp_owner == SRC_ALU);
        lsu_rvalid_o = rsp_valid & (rsp_owner == SRC_LSU);
        alu_first_o  = alu_rvalid_o ? rsp_entry.first : '0;
        alu_last_o   = alu_rvalid_o ? rsp_entry.last  : '0;
        alu_hit_o    = alu_rvalid_o & rsp_entry.valid;
        lsu_first_o  = lsu_rvalid_o ? rsp_entry.first : '0;
        lsu_last_o   = lsu_rvalid_o ? rsp_entry.last  : '0;
        lsu_hit_o    = lsu_rvalid_o & rsp_entry.valid;
    end

endmodule

// File: tb/tb_insa_buf_ctrl.sv
// Self-checking bench for insa_buf_ctrl: vector table, corner sequences and random traffic.
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_insa_buf_ctrl;

  localparam int DEPTH = 1024;
  localparam int IDX_W = 10;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              alu_req, lsu_req, clr_req;
  logic [19:0]       alu_idx, lsu_idx;
  logic              alu_gnt_o, alu_rvalid_o, alu_hit_o;
  logic              lsu_gnt_o, lsu_rvalid_o, lsu_hit_o;
  logic [31:0]       alu_first_o, alu_last_o, lsu_first_o, lsu_last_o;
  logic              clr_busy_o, mem_req_o, mem_we_o;
  logic [IDX_W-1:0]  mem_addr_o;
  logic [31:0]       mem_first_i, mem_last_i;
  logic              mem_valid_i;

  insa_buf_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .alu_req_i    (alu_req),
    .alu_idx_i    (alu_idx),
    .alu_gnt_o    (alu_gnt_o),
    .alu_rvalid_o (alu_rvalid_o),
    .alu_first_o  (alu_first_o),
    .alu_last_o   (alu_last_o),
    .alu_hit_o    (alu_hit_o),
    .lsu_req_i    (lsu_req),
    .lsu_idx_i    (lsu_idx),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_first_o  (lsu_first_o),
    .lsu_last_o   (lsu_last_o),
    .lsu_hit_o    (lsu_hit_o),
    .clr_req_i    (clr_req),
    .clr_busy_o   (clr_busy_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_first_i  (mem_first_i),
    .mem_last_i   (mem_last_i),
    .mem_valid_i  (mem_valid_i)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural RAM contents (what the DUT really writes) and the reference copy.
  bit [31:0] ram_first [DEPTH];
  bit [31:0] ram_last  [DEPTH];
  bit        ram_valid [DEPTH];
  bit [31:0] exp_first [DEPTH];
  bit [31:0] exp_last  [DEPTH];
  bit        exp_valid [DEPTH];

  // Reference model state.
  int        m_clr_left;
  bit        m_lsu_turn;
  bit        m_rsp_v, m_rsp_lsu, m_rsp_hit;
  bit [31:0] m_rsp_first, m_rsp_last;

  // Last sampled outputs, for sequence-level checks.
  bit        s_busy, s_agnt, s_lgnt, s_mreq, s_arv, s_lrv, s_ahit;
  bit [31:0] s_afirst, s_alast;

  typedef struct {
    bit a_req; int a_idx; bit l_req; int l_idx;
    bit a_gnt; bit l_gnt; bit mreq; bit a_rv; bit l_rv;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clr_left = 0;
    m_lsu_turn = 1'b0;
    m_rsp_v    = 1'b0;
    m_rsp_lsu  = 1'b0;
    m_rsp_hit  = 1'b0;
    m_rsp_first = '0;
    m_rsp_last  = '0;
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model, then RAM at posedge.
  task automatic cycle();
    bit busy_e, ag_e, lg_e, mreq_e, mwe_e, inr, arv_e, lrv_e;
    int addr_e, gidx, c_addr;
    bit c_req, c_we;
    @(negedge clk);
    busy_e = (m_clr_left > 0);
    ag_e = 0; lg_e = 0; mreq_e = 0; mwe_e = 0; addr_e = 0;
    if (busy_e) begin
      mreq_e = 1; mwe_e = 1; addr_e = DEPTH - m_clr_left;
    end else if (!clr_req) begin
      if (alu_req && lsu_req) begin
        if (m_lsu_turn) lg_e = 1; else ag_e = 1;
      end else if (alu_req) ag_e = 1;
      else if (lsu_req) lg_e = 1;
    end
    gidx = ag_e ? int'(alu_idx) : int'(lsu_idx);
    inr  = (gidx < DEPTH);
    if (ag_e || lg_e) begin
      mreq_e = inr;
      addr_e = inr ? gidx : 0;
    end
    arv_e = m_rsp_v && !m_rsp_lsu;
    lrv_e = m_rsp_v && m_rsp_lsu;
    `CHK("alu_gnt", alu_gnt_o, ag_e);
    `CHK("lsu_gnt", lsu_gnt_o, lg_e);
    `CHK("clr_busy", clr_busy_o, busy_e);
    `CHK("mem_req", mem_req_o, mreq_e);
    `CHK("mem_we", mem_we_o, mwe_e);
    if (mreq_e) `CHK("mem_addr", mem_addr_o, addr_e);
    `CHK("alu_rvalid", alu_rvalid_o, arv_e);
    `CHK("alu_first", alu_first_o, arv_e ? m_rsp_first : 32'h0);
    `CHK("alu_last", alu_last_o, arv_e ? m_rsp_last : 32'h0);
    `CHK("alu_hit", alu_hit_o, arv_e && m_rsp_hit);
    `CHK("lsu_rvalid", lsu_rvalid_o, lrv_e);
    `CHK("lsu_first", lsu_first_o, lrv_e ? m_rsp_first : 32'h0);
    `CHK("lsu_last", lsu_last_o, lrv_e ? m_rsp_last : 32'h0);
    `CHK("lsu_hit", lsu_hit_o, lrv_e && m_rsp_hit);
    s_busy = clr_busy_o; s_agnt = alu_gnt_o; s_lgnt = lsu_gnt_o; s_mreq = mem_req_o;
    s_arv = alu_rvalid_o; s_lrv = lsu_rvalid_o; s_ahit = alu_hit_o;
    s_afirst = alu_first_o; s_alast = alu_last_o;
    if (busy_e) begin
      exp_valid[addr_e] = 1'b0;
      m_clr_left--;
    end else if (clr_req) begin
      m_clr_left = DEPTH;
    end
    m_rsp_v     = ag_e || lg_e;
    m_rsp_lsu   = lg_e;
    m_rsp_first = (m_rsp_v && inr) ? exp_first[gidx] : 32'h0;
    m_rsp_last  = (m_rsp_v && inr) ? exp_last[gidx]  : 32'h0;
    m_rsp_hit   = m_rsp_v && inr && exp_valid[gidx];
    if (ag_e) m_lsu_turn = 1'b1;
    if (lg_e) m_lsu_turn = 1'b0;
    c_req = (mem_req_o === 1'b1); c_we = (mem_we_o === 1'b1); c_addr = int'(mem_addr_o);
    @(posedge clk);
    mem_first_i = $urandom;
    mem_last_i  = $urandom;
    mem_valid_i = 1'($urandom_range(0, 1));
    if (c_req && c_we) ram_valid[c_addr] = 1'b0;
    else if (c_req) begin
      mem_first_i = ram_first[c_addr];
      mem_last_i  = ram_last[c_addr];
      mem_valid_i = ram_valid[c_addr];
    end
    #1;
  endtask

  task automatic idle_inputs();
    alu_req = 0; lsu_req = 0; clr_req = 0; alu_idx = '0; lsu_idx = '0;
  endtask

  // Clear sequence; optional second pulse at clear cycle 10; LSU optionally requesting throughout.
  task automatic run_clear(input bit lsu_waiting, input bit second_pulse, input string tag);
    int n;
    bit done;
    lsu_req = lsu_waiting; lsu_idx = 20'd3;
    clr_req = 1;
    cycle();
    `CHK({tag, "_no_gnt_on_pulse"}, s_lgnt, 1'b0);
    n = 0; done = 0;
    for (int k = 0; k < 2 * DEPTH && !done; k++) begin
      clr_req = (second_pulse && k == 10);
      cycle();
      if (s_busy) n++;
      else begin
        done = 1;
        if (lsu_waiting) `CHK({tag, "_lsu_after_busy"}, s_lgnt, 1'b1);
      end
    end
    clr_req = 0;
    `CHK({tag, "_busy_cycles"}, n, DEPTH);
    cycle();
    lsu_req = 0;
  endtask

  initial begin
    rst_ni = 0;
    idle_inputs();
    mem_first_i = '0; mem_last_i = '0; mem_valid_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_first[i] = $urandom;
      ram_last[i]  = $urandom;
      ram_valid[i] = 1'($urandom_range(0, 1));
    end
    ram_first[5] = 32'h1000; ram_last[5] = 32'h10FF; ram_valid[5] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_first[i] = ram_first[i]; exp_last[i] = ram_last[i]; exp_valid[i] = ram_valid[i];
    end
    model_reset();

    vecs[0] = '{1, 5, 1, 9, 1, 0, 1, 0, 0};
    vecs[1] = '{1, 5, 1, 9, 0, 1, 1, 1, 0};
    vecs[2] = '{1, 5, 1, 9, 1, 0, 1, 0, 1};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[4] = '{1, 5, 0, 0, 1, 0, 1, 0, 0};
    vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[6] = '{1, 1024, 0, 0, 1, 0, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[8] = '{0, 0, 1, 1025, 0, 1, 0, 0, 0};
    vecs[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

    repeat (2) @(posedge clk);
    #3 rst_ni = 1;
    @(posedge clk); #1;

    n_tests++;
    if (clr_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %0b", clr_busy_o);
    end
    n_tests++;
    if (mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mem_req: got %0b", mem_req_o);
    end
    n_tests++;
    if (alu_rvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_alu_rvalid: got %0b", alu_rvalid_o);
    end
    n_tests++;
    if (lsu_rvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_lsu_rvalid: got %0b", lsu_rvalid_o);
    end

    // Vector table straight after reset.
    for (int i = 0; i < 10; i++) begin
      alu_req = vecs[i].a_req; alu_idx = 20'(vecs[i].a_idx);
      lsu_req = vecs[i].l_req; lsu_idx = 20'(vecs[i].l_idx);
      cycle();
      n_tests++;
      if (s_agnt !== vecs[i].a_gnt) begin
        n_fail++;
        $display("FAIL vec%0d_alu_gnt: got %0b expected %0b", i, s_agnt, vecs[i].a_gnt);
      end
      n_tests++;
      if (s_lgnt !== vecs[i].l_gnt) begin
        n_fail++;
        $display("FAIL vec%0d_lsu_gnt: got %0b expected %0b", i, s_lgnt, vecs[i].l_gnt);
      end
      n_tests++;
      if (s_mreq !== vecs[i].mreq) begin
        n_fail++;
        $display("FAIL vec%0d_mem_req: got %0b expected %0b", i, s_mreq, vecs[i].mreq);
      end
      n_tests++;
      if (s_arv !== vecs[i].a_rv) begin
        n_fail++;
        $display("FAIL vec%0d_alu_rvalid: got %0b expected %0b", i, s_arv, vecs[i].a_rv);
      end
      n_tests++;
      if (s_lrv !== vecs[i].l_rv) begin
        n_fail++;
        $display("FAIL vec%0d_lsu_rvalid: got %0b expected %0b", i, s_lrv, vecs[i].l_rv);
      end
      if (i == 5) begin
        `CHK("idx5_first", s_afirst, 32'h1000);
        `CHK("idx5_last", s_alast, 32'h10FF);
        `CHK("idx5_hit", s_ahit, 1'b1);
      end
      if (i == 7) begin
        `CHK("oor_first", s_afirst, 32'h0);
        `CHK("oor_hit", s_ahit, 1'b0);
      end
    end
    idle_inputs();

    // Random traffic with occasional clear pulses.
    for (int i = 0; i < 400; i++) begin
      alu_req = 1'($urandom_range(0, 1));
      lsu_req = 1'($urandom_range(0, 1));
      alu_idx = 20'($urandom_range(0, DEPTH + 80));
      lsu_idx = 20'($urandom_range(0, DEPTH + 80));
      clr_req = ($urandom_range(0, 299) == 0);
      cycle();
    end
    idle_inputs();
    while (m_clr_left > 0) cycle();

    // Reset at clear cycle 100, with an ALU request pending.
    clr_req = 1;
    cycle();
    clr_req = 0;
    alu_req = 1; alu_idx = 20'd7;
    repeat (100) cycle();
    rst_ni = 0;
    #1;
    `CHK("rstclr_busy", clr_busy_o, 1'b0);
    `CHK("rstclr_mem_req", mem_req_o, 1'b0);
    `CHK("rstclr_mem_we", mem_we_o, 1'b0);
    `CHK("rstclr_mem_addr", mem_addr_o, 0);
    `CHK("rstclr_alu_gnt", alu_gnt_o, 1'b0);
    `CHK("rstclr_lsu_gnt", lsu_gnt_o, 1'b0);
    `CHK("rstclr_alu_rvalid", alu_rvalid_o, 1'b0);
    `CHK("rstclr_alu_first", alu_first_o, 32'h0);
    model_reset();
    @(posedge clk);
    #3 rst_ni = 1;
    cycle();
    `CHK("rstclr_alu_gnt_after", s_agnt, 1'b1);
    alu_req = 0;
    cycle();

    // Random reads after the partial clear: low entries cleared, the rest untouched.
    for (int i = 0; i < 150; i++) begin
      alu_req = 1'($urandom_range(0, 1));
      lsu_req = 1'($urandom_range(0, 1));
      alu_idx = 20'($urandom_range(0, 200));
      lsu_idx = 20'($urandom_range(0, DEPTH + 20));
      cycle();
    end
    idle_inputs();
    cycle();

    run_clear(1'b0, 1'b1, "clr_double");
    run_clear(1'b1, 1'b0, "clr_lsu");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
